// File: rtl/serial_framer_pkg.sv
// Shared definitions for the serial nibble framer.
//   state_t      : framer FSM state (HUNT searching for sync, LOCKED packing payload)
//   SYNC_DEFAULT : default bit-aligned sync pattern, bit 3 oldest
//   NIBBLE_W     : width of one packed nibble
package serial_framer_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [3:0]  SYNC_DEFAULT = 4'b1011;
    localparam int unsigned NIBBLE_W     = 4;

endpackage

// File: rtl/serial_nibble_framer_fifo.sv
// Synchronous FIFO holding packed nibbles.
//   clk, rst : clock and asynchronous active-high reset
//   push/din : write request and data; ignored when full unless a pop happens too
//   pop/dout : read request and head-of-queue data (registered storage)
//   full     : DEPTH entries held
//   empty    : no entries held
module nibble_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == COUNT_MAX);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_nibble_framer.sv
// Serial nibble framer: hunts for a bit-aligned sync nibble, then packs each
// following group of 4 valid bits into a nibble, buffers it in a FIFO and
// returns to hunting after FRAME_NIBBLES nibbles.
//   clk, rst   : clock and asynchronous active-high reset
//   D, d_valid : serial data bit and its qualifier
//   out_ready  : consumer accepts out_data
//   out_valid  : FIFO non-empty
//   out_data   : head nibble, bit 3 oldest
//   locked     : framer is in LOCKED
//   frame_done : one-cycle pulse after the frame's final nibble
//   overflow   : sticky, a nibble was dropped because the FIFO was full
module serial_nibble_framer
    import serial_framer_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] SYNC          = SYNC_DEFAULT,
    parameter int unsigned         FRAME_NIBBLES = 8,
    parameter int unsigned         FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                D,
    input  logic                d_valid,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [NIBBLE_W-1:0] out_data,
    output logic                locked,
    output logic                frame_done,
    output logic                overflow
);

    localparam logic [7:0] LAST_NIB = 8'(FRAME_NIBBLES - 1);

    state_t              state, state_next;
    logic [NIBBLE_W-1:0] win, win_next, win_shift;
    logic [1:0]          bit_cnt, bit_cnt_next;
    logic [7:0]          nib_cnt, nib_cnt_next;
    logic                push, pop, frame_end;
    logic                fifo_full, fifo_empty;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign locked    = (state == LOCKED);

    always_comb begin
        state_next   = state;
        win_next     = win;
        bit_cnt_next = bit_cnt;
        nib_cnt_next = nib_cnt;
        push         = 1'b0;
        frame_end    = 1'b0;
        win_shift    = {win[NIBBLE_W-2:0], D};
        if (d_valid) begin
            win_next = win_shift;
            case (state)
                HUNT: begin
                    if (win_shift == SYNC) begin
                        state_next   = LOCKED;
                        bit_cnt_next = '0;
                        nib_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    bit_cnt_next = bit_cnt + 2'd1;
                    if (bit_cnt == 2'd3) begin
                        push         = 1'b1;
                        nib_cnt_next = nib_cnt + 8'd1;
                        if (nib_cnt == LAST_NIB) begin
                            // Clearing the window forces a fresh 4-bit sync after each frame.
                            frame_end    = 1'b1;
                            state_next   = HUNT;
                            win_next     = '0;
                            nib_cnt_next = '0;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win        <= '0;
            bit_cnt    <= '0;
            nib_cnt    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            win        <= win_next;
            bit_cnt    <= bit_cnt_next;
            nib_cnt    <= nib_cnt_next;
            frame_done <= frame_end;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    nibble_fifo #(
        .WIDTH (NIBBLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (win_shift),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
